// File: rtl/spi_reg_bridge.sv
// SPI mode-0 target that turns {wr_rdn, addr} + data frames into register-bank requests.
// Define SPI_AUTOINC_EN to enable burst transfers with address auto-increment.
module spi_reg_bridge #(
    parameter int ADDR_W = 7,
    parameter int REG_W  = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              wr_rdn,
    output logic [ADDR_W-1:0] addr,
    output logic [REG_W-1:0]  wdata,
    output logic              we,
    input  logic [REG_W-1:0]  rdata,
    input  logic              ack,
    input  logic              err,
    output logic              txn_err,
    output logic [2:0]        dbg_state_o
);
    localparam int SH_W  = (REG_W > 8) ? REG_W : 8;
    localparam int CNT_W = $clog2(SH_W) + 1;

    typedef enum logic [2:0] {IDLE, CMD, DATA, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic              cs_prev_q, sclk_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-2:0]   rx_q, rx_d;
    logic [REG_W-1:0]  tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              load_q, load_d;
    logic              cs_abort_q, cs_abort_d;
    logic              wr_rdn_q, wr_rdn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0]  wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              txn_err_q, txn_err_d;

    logic              cs_s, sclk_s, mosi_s;
    logic              cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [SH_W-1:0]   new_sh;

    assign cs_s      = cs_sync_q[1];
    assign sclk_s    = sclk_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign new_sh    = {rx_q, mosi_s};

    // cs_n synchronizer resets high so reset never looks like a frame start
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cs_sync_q   <= 2'b11;
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            load_q     <= 1'b0;
            cs_abort_q <= 1'b0;
            wr_rdn_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            txn_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            load_q     <= load_d;
            cs_abort_q <= cs_abort_d;
            wr_rdn_q   <= wr_rdn_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            txn_err_q  <= txn_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        load_d     = 1'b0;
        cs_abort_d = cs_abort_q;
        wr_rdn_d   = wr_rdn_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        txn_err_d  = 1'b0;

        // rdata reflects the freshly registered addr one cycle after it changes
        if (load_q) begin
            tx_d   = rdata;
            miso_d = 1'b0;
        end

        if (!ena) begin
            state_d    = IDLE;
            we_d       = 1'b0;
            miso_d     = 1'b0;
            cs_abort_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (cs_rise) begin
                        state_d = IDLE;
                    end else if (sclk_rise) begin
                        rx_d  = new_sh[SH_W-2:0];
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            wr_rdn_d = new_sh[ADDR_W];
                            addr_d   = new_sh[ADDR_W-1:0];
                            cnt_d    = '0;
                            load_d   = ~new_sh[ADDR_W];
                            miso_d   = 1'b0;
                            state_d  = DATA;
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        state_d = IDLE;
                    end else if (sclk_rise) begin
                        rx_d  = new_sh[SH_W-2:0];
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(REG_W - 1)) begin
                            cnt_d = '0;
                            if (wr_rdn_q) begin
                                wdata_d = new_sh[REG_W-1:0];
                                we_d    = 1'b1;
                                state_d = WRITE;
                            end else begin
`ifdef SPI_AUTOINC_EN
                                addr_d = addr_q + ADDR_W'(1);
                                load_d = 1'b1;
`else
                                state_d = DONE;
`endif
                            end
                        end
                    end else if (sclk_fall && !wr_rdn_q) begin
                        miso_d = tx_q[REG_W-1];
                        tx_d   = {tx_q[REG_W-2:0], 1'b0};
                    end
                end
                WRITE: begin
                    if (cs_rise) cs_abort_d = 1'b1;
                    if (we_q && ack) begin
                        we_d       = 1'b0;
                        txn_err_d  = err;
                        cs_abort_d = 1'b0;
                        if (cs_abort_q || cs_rise || cs_s) begin
                            state_d = IDLE;
                        end else begin
`ifdef SPI_AUTOINC_EN
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = DATA;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    if (cs_rise) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign spi_miso    = miso_q & (state_q == DATA) & ~cs_s;
    assign wr_rdn      = wr_rdn_q;
    assign addr        = addr_q;
    assign wdata       = wdata_q;
    assign we          = we_q;
    assign txn_err     = txn_err_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: SPI master driver tasks, register-bank model, scoreboard monitors.
module tb_spi_reg_bridge;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       ena = 1'b1;
    logic       spi_cs_n = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       wr_rdn;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
    logic       ack;
    logic       err;
    logic       txn_err;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;

    // entry: {err, we_len[3:0], addr[6:0], wdata[7:0]}
    logic [19:0] exp_q[$];
    logic [7:0]  rd_exp_q[$];

    int         ack_dly = 0;
    logic       err_cfg = 1'b0;
    logic [3:0] we_cnt = '0;

    spi_reg_bridge dut (
        .clk(clk), .rstb(rstb), .ena(ena),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .wr_rdn(wr_rdn), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .ack(ack), .err(err), .txn_err(txn_err), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // register bank model
    always @(posedge clk) we_cnt <= we ? we_cnt + 4'd1 : 4'd0;
    assign ack   = we && (int'(we_cnt) >= ack_dly);
    assign err   = err_cfg;
    assign rdata = (addr == 7'h05) ? 8'hA7 : ({1'b0, addr} ^ 8'h5A);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [31:0] d, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = d[i];
            clks(HALF);
            spi_sclk = 1'b1;
            clks(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_xfer(input logic [31:0] d, input int nbits);
        spi_cs_n = 1'b0;
        clks(6);
        spi_bits(d, nbits);
        clks(HALF);
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        clks(12);
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [7:0] d, input logic [3:0] len,
                           input logic e);
        exp_q.push_back({e, len, a, d});
    endtask

    // write-side monitor
    logic       err_pend = 1'b0;
    logic       exp_err  = 1'b0;
    int         mon_len  = 0;
    logic [19:0] ent;
    always @(negedge clk) begin
        if (rstb) begin
            if (err_pend) begin
                chk("txn_err", {31'd0, txn_err}, {31'd0, exp_err});
                err_pend = 1'b0;
            end else if (txn_err) begin
                chk("txn_err_spurious", {31'd0, txn_err}, 32'd0);
            end
            if (we) begin
                mon_len++;
                if (ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", {31'd0, we}, 32'd0);
                    end else begin
                        ent = exp_q.pop_front();
                        chk("wr_addr", {25'd0, addr}, {25'd0, ent[14:8]});
                        chk("wr_data", {24'd0, wdata}, {24'd0, ent[7:0]});
                        chk("wr_rdn", {31'd0, wr_rdn}, 32'd1);
                        chk("we_len", mon_len, {28'd0, ent[18:15]});
                        exp_err  = ent[19];
                        err_pend = 1'b1;
                    end
                    mon_len = 0;
                end
            end else begin
                mon_len = 0;
            end
        end else begin
            err_pend = 1'b0;
            mon_len  = 0;
        end
    end

    // SPI-side monitor: acts as the master's receive shift register
    int         sp_bits = 0;
    logic [7:0] sp_cmd  = '0;
    logic [7:0] sp_rx   = '0;
    logic [7:0] rd_exp;
    always @(posedge spi_sclk) begin
        if (!spi_cs_n) begin
            if (sp_bits < 8) sp_cmd = {sp_cmd[6:0], spi_mosi};
            else             sp_rx  = {sp_rx[6:0], spi_miso};
            sp_bits++;
        end
    end
    always @(posedge spi_cs_n) begin
        if (sp_bits == 16 && !sp_cmd[7]) begin
            if (rd_exp_q.size() == 0) begin
                chk("unexpected_read", {24'd0, sp_rx}, 32'hFFFF_FFFF);
            end else begin
                rd_exp = rd_exp_q.pop_front();
                chk("rd_miso", {24'd0, sp_rx}, {24'd0, rd_exp});
            end
        end
        sp_bits = 0;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clks(3);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_wr_rdn", {31'd0, wr_rdn}, 32'd0);
        chk("rst_addr", {25'd0, addr}, 32'd0);
        chk("rst_wdata", {24'd0, wdata}, 32'd0);
        chk("rst_txn_err", {31'd0, txn_err}, 32'd0);
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        rstb = 1'b1;
        clks(5);

        // basic write
        push_wr(7'h05, 8'h3C, 4'd1, 1'b0);
        spi_xfer(32'h853C, 16);

        // basic read: 0xA7 from addr 0x05
        rd_exp_q.push_back(8'hA7);
        spi_xfer(32'h0500, 16);

        // aborted command after 5 bits, then a full write
        spi_xfer(32'h10, 5);
        push_wr(7'h01, 8'h11, 4'd1, 1'b0);
        spi_xfer(32'h8111, 16);

        // slow ack with error
        ack_dly = 3;
        err_cfg = 1'b1;
        push_wr(7'h02, 8'h55, 4'd4, 1'b1);
        spi_xfer(32'h8255, 16);
        ack_dly = 0;
        err_cfg = 1'b0;

        // address wrap in a multi-word frame
        push_wr(7'h7F, 8'h01, 4'd1, 1'b0);
`ifdef SPI_AUTOINC_EN
        push_wr(7'h00, 8'h02, 4'd1, 1'b0);
`endif
        spi_xfer(32'hFF0102, 24);

        // disabled block ignores a frame
        ena = 1'b0;
        spi_xfer(32'h8622, 16);
        ena = 1'b1;
        clks(4);

        // read from another address: 0x2A ^ 0x5A = 0x70
        rd_exp_q.push_back(8'h70);
        spi_xfer(32'h2A00, 16);

        // reset in the middle of a write data phase
        spi_cs_n = 1'b0;
        clks(6);
        spi_bits(32'h837, 12);
        rstb     = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, we}, 32'd0);
        chk("mid_rst_wr_rdn", {31'd0, wr_rdn}, 32'd0);
        chk("mid_rst_addr", {25'd0, addr}, 32'd0);
        chk("mid_rst_wdata", {24'd0, wdata}, 32'd0);
        chk("mid_rst_txn_err", {31'd0, txn_err}, 32'd0);
        chk("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
        clks(3);
        rstb = 1'b1;
        clks(6);
        push_wr(7'h04, 8'h99, 4'd1, 1'b0);
        spi_xfer(32'h8499, 16);

        clks(20);
        chk("wr_left", exp_q.size(), 32'd0);
        chk("rd_left", rd_exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 7: register address width; the command byte is {wr_rdn, addr}, so ADDR_W+1 = 8.
REQ-002 SHALL have parameter REG_W, default 8: data width, shifted MSB first.
REQ-003 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-004 SHALL have port rstb, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port ena, input, 1: block enable; 0 forces IDLE.
REQ-006 SHALL have ports spi_cs_n, spi_sclk and spi_mosi, each input, 1: asynchronous SPI target pins.
REQ-007 SHALL have port spi_miso, output, 1: serial read data.
REQ-008 SHALL have ports wr_rdn (output, 1), addr (output, ADDR_W), wdata (output, REG_W) and we (output, 1): register-bank request.
REQ-009 SHALL have ports rdata (input, REG_W), ack (input, 1) and err (input, 1): register-bank response.
REQ-010 SHALL have port txn_err, output, 1: one-cycle pulse when a write completes with err=1.

Function
REQ-011 SHALL implement SPI mode 0: sample MOSI on SCLK rise, change MISO on SCLK fall, MSB first.
REQ-012 SHALL pass spi_cs_n, spi_sclk and spi_mosi through 2-flop synchronizers and detect SCLK edges on the synchronized signal; SCLK frequency is at most clk/8.
REQ-013 SHALL use FSM states IDLE, CMD, DATA, WRITE and DONE.
REQ-014 SHALL move IDLE->CMD on synchronized cs_n falling edge with ena=1, clearing the bit counter.
REQ-015 In CMD, SHALL shift 8 bits; on the 8th rising edge latch wr_rdn and addr, then go to DATA.
REQ-016 For a read, SHALL load a REG_W shift register with rdata on the clk cycle after addr is latched, before the first data-phase SCLK fall, and shift it out on spi_miso at each SCLK fall.
REQ-017 spi_miso SHALL be 0 in IDLE, CMD and DONE, and whenever synchronized cs_n is high.
REQ-018 For a write, SHALL latch wdata on the REG_W-th data rising edge, then go to WRITE.
REQ-019 In WRITE, SHALL assert we with stable addr/wdata/wr_rdn=1, and hold we until a cycle with ack=1; we drops the cycle after.
REQ-020 SHALL pulse txn_err for one cycle when err=1 in the we&ack cycle.
REQ-021 After a read data phase or a completed write, SHALL go to DONE (or re-enter DATA per REQ-029).
REQ-022 SHALL ignore further SCLK edges in DONE until cs_n rises.
REQ-023 On cs_n rising in CMD or DATA, SHALL return to IDLE, discard partial bits and never assert we.
REQ-024 On cs_n rising in WRITE, SHALL complete the pending write (we until ack) and then go to IDLE.
REQ-025 ena=0 SHALL force IDLE next cycle with we=0 and spi_miso=0.
REQ-026 we SHALL never be asserted for a read command (wr_rdn=0).

Reset
REQ-027 On rstb low, SHALL asynchronously clear all outputs: spi_miso, we, wr_rdn, addr, wdata and txn_err = 0.
REQ-028 On rstb low, SHALL clear the synchronizers (cs_n synchronizers to 1), counters and shift registers, and set FSM=IDLE; rstb low mid-frame aborts with no write.

Configuration
REQ-029 With SPI_AUTOINC_EN defined: after each data word, the DATA state SHALL continue with addr+1 (mod 2^ADDR_W) for burst read/write until cs_n rises; each write word gets its own WRITE cycle and reads reload rdata per REQ-016. Without it, DATA runs exactly once, then DONE.

Verification
REQ-030 Write cmd 0x85, data 0x3C -> one we pulse with addr=0x05, wdata=0x3C, wr_rdn=1; txn_err=0.
REQ-031 Read cmd 0x05 with rdata=0xA7 -> MISO bits 1,0,1,0,0,1,1,1 over the data phase; we never asserted.
REQ-032 cs_n raised after 5 command bits, then full write 0x81/0x11 -> only addr=0x01, wdata=0x11 written.
REQ-033 Write 0x82/0x55 with ack held 0 for 3 cycles and err=1 at ack -> we high for 4 cycles, one txn_err pulse.
REQ-034 SPI_AUTOINC_EN: write cmd 0xFF then 0x01,0x02 -> writes addr 0x7F=0x01 and 0x00=0x02; without the macro, only 0x7F=0x01.
REQ-035 rstb pulsed low mid data phase -> all outputs 0 immediately, no we, next frame decodes normally.
